// File: rtl/ir_fetch_ctrl_pkg.sv
// rtl/ir_fetch_ctrl_pkg.sv - timing-state encoding and opcode constants shared by the IR fetch controller
package ir_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } tstate_e;

    localparam logic [7:0] OPC_BRK = 8'h00;

    // Jam opcodes are x2 except 82/A2/C2/E2; bit n of the mask marks high nibble n.
    localparam logic [3:0]  JAM_LO_NIBBLE = 4'h2;
    localparam logic [15:0] JAM_HI_MASK   = 16'hAAFF;

    function automatic logic is_jam_opc(input logic [7:0] opc);
        return (opc[3:0] == JAM_LO_NIBBLE) && JAM_HI_MASK[opc[7:4]];
    endfunction

endpackage

// File: rtl/ir_fetch_ctrl_if.sv
// rtl/ir_fetch_ctrl_if.sv - predecode/random-logic side bundle of the IR fetch controller
interface ir_fetch_ctrl_if;

    logic [7:0] n_PD;
    logic       n_IMPLIED;
    logic       n_TWOCYCLE;
    logic       RDY;
    logic       INT_REQ;
    logic       ENDX;

    logic       Z_IR;
    logic [7:0] IR;
    logic [2:0] TSTATE;
    logic       SYNC;
    logic       PC_INC;
    logic       JAMMED;

    modport master (
        output n_PD, n_IMPLIED, n_TWOCYCLE, RDY, INT_REQ, ENDX,
        input  Z_IR, IR, TSTATE, SYNC, PC_INC, JAMMED
    );

    modport slave (
        input  n_PD, n_IMPLIED, n_TWOCYCLE, RDY, INT_REQ, ENDX,
        output Z_IR, IR, TSTATE, SYNC, PC_INC, JAMMED
    );

endinterface

// File: rtl/ir_tcount.sv
// rtl/ir_tcount.sv - T0..T6 timing counter with ENDX/T6 termination and stall
module ir_tcount
    import ir_fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    input  logic       endx,
    input  logic       two_cycle,
    output logic [2:0] tstate
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstate <= T1;
        end else if (adv) begin
            case (tstate)
                T0:             tstate <= T1;
                T1:             tstate <= two_cycle ? T0 : T2;
                T2, T3, T4, T5: tstate <= endx ? T0 : tstate + 3'd1;
                T6:             tstate <= T0;
                default:        tstate <= T1;
            endcase
        end
    end

endmodule

// File: rtl/ir_fetch_ctrl.sv
// rtl/ir_fetch_ctrl.sv - instruction register, interrupt BRK injection and fetch timing
// Optional KIL/jam halt support is compiled in with IR_FETCH_KIL_EN.
module ir_fetch_ctrl
    import ir_fetch_ctrl_pkg::*;
(
    input  logic           PHI2,
    input  logic           n_RES,
    ir_fetch_ctrl_if.slave bus
);

    logic [7:0] pd;
    logic [7:0] ir;
    logic [2:0] tstate;
    logic       z_ir;
    logic       impl_q;
    logic       jammed;
    logic       jam_hit;
    logic       fetch;
    logic       two_cycle;

    assign pd    = ~bus.n_PD;
    assign fetch = bus.RDY && (tstate == T1) && !jammed;

`ifdef IR_FETCH_KIL_EN
    assign jam_hit = fetch && !z_ir && is_jam_opc(pd);

    always_ff @(posedge PHI2 or negedge n_RES) begin
        if (!n_RES) begin
            jammed <= 1'b0;
        end else if (jam_hit) begin
            jammed <= 1'b1;
        end
    end
`else
    assign jam_hit = 1'b0;
    assign jammed  = 1'b0;
`endif

    // An injected BRK is never two-cycle, and a jam must land on T2 to freeze there.
    assign two_cycle = !bus.n_TWOCYCLE && !z_ir && !jam_hit;

    ir_tcount u_tcount (
        .clk       (PHI2),
        .rst_n     (n_RES),
        .adv       (bus.RDY && !jammed),
        .endx      (bus.ENDX),
        .two_cycle (two_cycle),
        .tstate    (tstate)
    );

    always_ff @(posedge PHI2 or negedge n_RES) begin
        if (!n_RES) begin
            ir     <= OPC_BRK;
            z_ir   <= 1'b1;
            impl_q <= 1'b0;
        end else if (fetch) begin
            ir     <= z_ir ? OPC_BRK : pd;
            impl_q <= !bus.n_IMPLIED;
            z_ir   <= 1'b0;
        end else if (bus.RDY && (tstate == T0) && bus.INT_REQ && !jammed) begin
            z_ir   <= 1'b1;
        end
    end

    assign bus.IR     = ir;
    assign bus.TSTATE = tstate;
    assign bus.SYNC   = (tstate == T1);
    assign bus.Z_IR   = z_ir;
    assign bus.JAMMED = jammed;
    assign bus.PC_INC = !jammed && !z_ir &&
                        ((tstate == T1) || ((tstate == T2) && !impl_q));

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// tb/tb_ir_fetch_ctrl.sv - self-checking bench for ir_fetch_ctrl against a behavioural model
module tb_ir_fetch_ctrl;

    logic PHI2;
    logic n_RES;
    int   checks;
    int   failures;

    ir_fetch_ctrl_if bus ();

    ir_fetch_ctrl dut (
        .PHI2  (PHI2),
        .n_RES (n_RES),
        .bus   (bus)
    );

    initial begin
        PHI2 = 1'b0;
        forever #5 PHI2 = ~PHI2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    int m_t, m_ir, m_z, m_impl, m_jam;

    byte unsigned jam_list [12] = '{8'h02, 8'h12, 8'h22, 8'h32, 8'h42, 8'h52,
                                    8'h62, 8'h72, 8'h92, 8'hB2, 8'hD2, 8'hF2};

    function automatic bit is_jam(int opc);
        foreach (jam_list[i]) if (int'(jam_list[i]) == opc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 1; m_ir = 0; m_z = 1; m_impl = 0; m_jam = 0;
    endtask

    task automatic model_edge();
        logic [7:0] pdv;
        int  opc;
        bit  jh;
        if (!n_RES) begin
            model_reset();
            return;
        end
        if (!bus.RDY || m_jam != 0) return;
        case (m_t)
            0: begin
                if (bus.INT_REQ) m_z = 1;
                m_t = 1;
            end
            1: begin
                pdv = ~bus.n_PD;
                opc = (m_z != 0) ? 0 : int'(pdv);
                jh  = 1'b0;
`ifdef IR_FETCH_KIL_EN
                jh  = (m_z == 0) && is_jam(opc);
`endif
                m_t    = (m_z == 0 && !bus.n_TWOCYCLE && !jh) ? 0 : 2;
                m_ir   = opc;
                m_impl = bus.n_IMPLIED ? 0 : 1;
                m_z    = 0;
                if (jh) m_jam = 1;
            end
            6: m_t = 0;
            default: m_t = bus.ENDX ? 0 : m_t + 1;
        endcase
    endtask

    function automatic int exp_pc_inc();
        if (m_jam != 0 || m_z != 0) return 0;
        if (m_t == 1) return 1;
        if (m_t == 2 && m_impl == 0) return 1;
        return 0;
    endfunction

    task automatic compare_all();
        check("tstate", bus.TSTATE, m_t);
        check("ir",     bus.IR,     m_ir);
        check("sync",   bus.SYNC,   (m_t == 1) ? 1 : 0);
        check("z_ir",   bus.Z_IR,   m_z);
        check("pc_inc", bus.PC_INC, exp_pc_inc());
        check("jammed", bus.JAMMED, m_jam);
    endtask

    task automatic step();
        model_edge();
        @(posedge PHI2);
        #1;
        compare_all();
    endtask

    task automatic goto_t1();
        for (int i = 0; i < 12; i++) begin
            if (m_t == 1 && m_jam == 0) break;
            bus.RDY = 1'b1; bus.ENDX = 1'b1; bus.INT_REQ = 1'b0;
            bus.n_TWOCYCLE = 1'b1; bus.n_IMPLIED = 1'b1; bus.n_PD = 8'hFF;
            step();
        end
        check("reach_t1", bus.TSTATE, 1);
    endtask

    task automatic async_reset();
        #2;
        n_RES = 1'b0;
        #1;
        model_reset();
        check("async_tstate", bus.TSTATE, 1);
        check("async_ir",     bus.IR,     0);
        compare_all();
    endtask

    initial begin
        checks = 0; failures = 0;
        n_RES = 1'b0;
        bus.n_PD = 8'hFF; bus.n_IMPLIED = 1'b1; bus.n_TWOCYCLE = 1'b1;
        bus.RDY = 1'b1; bus.INT_REQ = 1'b0; bus.ENDX = 1'b0;
        model_reset();

        // Reset state, then the first fetch after release is the injected BRK.
        step(); step();
        check("rst_sync", bus.SYNC, 1);
        check("rst_zir",  bus.Z_IR, 1);
        n_RES = 1'b1; bus.n_TWOCYCLE = 1'b0;
        step();
        check("brk_ir", bus.IR, 8'h00);
        check("brk_t2", bus.TSTATE, 2);
        check("brk_z",  bus.Z_IR, 0);

        // INX: two-cycle, implied.
        goto_t1();
        bus.n_PD = ~8'hE8; bus.n_TWOCYCLE = 1'b0; bus.n_IMPLIED = 1'b0; bus.ENDX = 1'b0;
        step();
        check("inx_ir", bus.IR, 8'hE8);
        check("inx_t0", bus.TSTATE, 0);
        check("inx_pc", bus.PC_INC, 0);
        step();
        check("inx_t1", bus.TSTATE, 1);

        // LDA abs with ENDX in T3.
        bus.n_PD = ~8'hAD; bus.n_TWOCYCLE = 1'b1; bus.n_IMPLIED = 1'b1; bus.ENDX = 1'b0;
        check("lda_pc_t1", bus.PC_INC, 1);
        step();
        check("lda_t2", bus.TSTATE, 2);
        check("lda_pc_t2", bus.PC_INC, 1);
        step();
        check("lda_t3", bus.TSTATE, 3);
        bus.ENDX = 1'b1;
        step();
        check("lda_t0", bus.TSTATE, 0);
        bus.ENDX = 1'b0;
        step();
        check("lda_t1b", bus.TSTATE, 1);

        // Interrupt taken in T0 forces BRK on the next fetch.
        bus.n_PD = ~8'hEA; bus.n_TWOCYCLE = 1'b0; bus.n_IMPLIED = 1'b0;
        step();
        bus.INT_REQ = 1'b1;
        step();
        check("int_z1", bus.Z_IR, 1);
        check("int_t1", bus.TSTATE, 1);
        bus.INT_REQ = 1'b0; bus.n_PD = ~8'hA9; bus.n_TWOCYCLE = 1'b0; bus.n_IMPLIED = 1'b1;
        step();
        check("int_ir", bus.IR, 8'h00);
        check("int_z0", bus.Z_IR, 0);

        // Stall in T3, then asynchronous reset in T4.
        goto_t1();
        bus.n_PD = ~8'hAD; bus.n_TWOCYCLE = 1'b1; bus.n_IMPLIED = 1'b1; bus.ENDX = 1'b0;
        step(); step();
        bus.RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ENDX = 1'($urandom); bus.INT_REQ = 1'($urandom); bus.n_PD = 8'($urandom);
            step();
            check("stall_t", bus.TSTATE, 3);
            check("stall_ir", bus.IR, 8'hAD);
            check("stall_z", bus.Z_IR, 0);
        end
        bus.RDY = 1'b1; bus.ENDX = 1'b0; bus.INT_REQ = 1'b0;
        step();
        check("t4", bus.TSTATE, 4);
        async_reset();
        step();
        n_RES = 1'b1;
        step();

        // Jam opcode fetch.
        goto_t1();
        bus.n_PD = ~8'h02; bus.n_TWOCYCLE = 1'b0; bus.n_IMPLIED = 1'b1; bus.ENDX = 1'b0;
        step();
`ifdef IR_FETCH_KIL_EN
        check("kil_jam", bus.JAMMED, 1);
        for (int i = 0; i < 10; i++) begin
            bus.ENDX = 1'($urandom); bus.INT_REQ = 1'b1; bus.RDY = 1'($urandom);
            step();
            check("kil_t2", bus.TSTATE, 2);
            check("kil_pc", bus.PC_INC, 0);
        end
        n_RES = 1'b0; bus.INT_REQ = 1'b0;
        step();
        n_RES = 1'b1;
`else
        check("kil_ir", bus.IR, 8'h02);
        check("kil_t0", bus.TSTATE, 0);
        check("kil_nojam", bus.JAMMED, 0);
`endif

        // Randomized traffic with occasional sync/async resets.
        for (int i = 0; i < 500; i++) begin
            bus.RDY        = ($urandom_range(3) != 0);
            bus.INT_REQ    = ($urandom_range(4) == 0);
            bus.ENDX       = ($urandom_range(2) == 0);
            bus.n_PD       = 8'($urandom);
            bus.n_IMPLIED  = 1'($urandom);
            bus.n_TWOCYCLE = 1'($urandom);
            n_RES          = ($urandom_range(39) != 0) && !(m_jam != 0 && $urandom_range(7) == 0);
            if (n_RES && $urandom_range(59) == 0) async_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_fetch_ctrl.md
IR_FETCH_CTRL -- requirements
Module: ir_fetch_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; the ports are PHI2 (input, 1, clock, rising edge active) and n_RES (input, 1, async active-low reset).
REQ-002 SHALL have n_PD (input, 8): inverted predecoded opcode; PD = ~n_PD.
REQ-003 SHALL have n_IMPLIED and n_TWOCYCLE (inputs, 1 each): inverted predecode flags.
REQ-004 SHALL have RDY (input, 1): 1 = advance; 0 = stall.
REQ-005 SHALL have INT_REQ (input, 1): pending interrupt.
REQ-006 SHALL have ENDX (input, 1): end-of-instruction from the random logic.
REQ-007 SHALL have Z_IR (output, 1): forces predecode to present BRK (0x00).
REQ-008 SHALL have IR (output, 8): instruction register.
REQ-009 SHALL have TSTATE (output, 3): current timing state.
REQ-010 SHALL have SYNC (output, 1): opcode fetch cycle.
REQ-011 SHALL have PC_INC (output, 1): PC increment request.
REQ-012 SHALL have JAMMED (output, 1): halt indicator, tied 0 when the KIL feature is compiled out.

Function
REQ-013 TSTATE SHALL use the encodings T0=0, T1=1, T2..T6=2..6; value 7 is illegal and SHALL recover to T1.
REQ-014 When RDY=0, all registers SHALL hold and all outputs SHALL be unchanged.
REQ-015 In T1 with RDY=1: IR SHALL load PD and IMPL_Q SHALL load ~n_IMPLIED; the next state SHALL be T0 if n_TWOCYCLE=0, else T2.
REQ-016 In T0 with RDY=1, the next state SHALL be T1.
REQ-017 In T2..T5 with RDY=1: next state SHALL be T0 if ENDX=1, else TSTATE+1.
REQ-018 In T6 with RDY=1, the next state SHALL be T0 regardless of ENDX.
REQ-019 SYNC SHALL equal (TSTATE==T1), decoded from registered state only.
REQ-020 Z_IR SHALL set when INT_REQ=1 in T0 with RDY=1, and SHALL clear at the end of the following T1 with RDY=1; with Z_IR=1 the fetch loads IR=0x00.
REQ-021 INT_REQ SHALL be ignored outside T0; in T0, INT_REQ dropping before the edge SHALL leave Z_IR unchanged.
REQ-022 PC_INC SHALL be 1 when SYNC=1 and Z_IR=0, or when TSTATE==T2, IMPL_Q=0 and Z_IR=0; otherwise PC_INC SHALL be 0.
REQ-023 Latency: an opcode on n_PD in T1 SHALL appear on IR one PHI2 edge later.

Reset
REQ-024 While n_RES=0, outputs SHALL be: IR=0x00, TSTATE=T1, SYNC=1, Z_IR=1, IMPL_Q=0, PC_INC=0, JAMMED=0.
REQ-025 Reset asserted mid-instruction SHALL take effect immediately, asynchronously, with no pending state retained.
REQ-026 After reset release, the first RDY=1 edge SHALL fetch injected BRK (IR=0x00) and go to T2.

Configuration
REQ-027 The macro IR_FETCH_KIL_EN SHALL select the KIL feature.
REQ-028 With IR_FETCH_KIL_EN defined: a fetch of any of the opcodes 02,12,22,32,42,52,62,72,92,B2,D2,F2 SHALL set JAMMED=1 and freeze TSTATE at T2 until reset; INT_REQ SHALL be ignored while jammed; PC_INC SHALL be 0 while jammed.
REQ-029 Without IR_FETCH_KIL_EN, these opcodes SHALL follow normal timing and JAMMED SHALL be constant 0.

Structure
REQ-030 The shared package SHALL hold the TSTATE enum (T0..T6), OPC_BRK=8'h00, and the JAM-opcode match constants (low nibble 2, excluding 82/A2/C2/E2).
REQ-031 The timing counter (T0..T6 sequencing, ENDX/T6 termination, stall) SHALL be one sub-module named ir_tcount; IR, Z_IR, IMPL_Q and KIL logic SHALL stay in the top module.

Verification
REQ-032 Reset release, RDY=1, n_PD=FF: IR=00 and TSTATE=T2 after 1 edge; Z_IR=0.
REQ-033 T1 with n_PD=~E8 (INX), n_TWOCYCLE=0, n_IMPLIED=0: IR=E8, then T0, then T1; PC_INC=0 in the T0 cycle.
REQ-034 T1 with n_PD=~AD (LDA abs), n_TWOCYCLE=1, ENDX pulsed in T3: sequence T2,T3,T0,T1; PC_INC=1 in T1 and T2.
REQ-035 INT_REQ=1 in T0: Z_IR=1 in the next T1; IR=00 regardless of n_PD=~A9; Z_IR=0 afterwards.
REQ-036 RDY=0 for 3 cycles in T3: TSTATE, IR and Z_IR are unchanged; n_RES pulsed low in T4 gives TSTATE=T1 and IR=00 immediately.
REQ-037 With IR_FETCH_KIL_EN, fetching 02 gives JAMMED=1 and TSTATE stuck at T2 for 10 cycles; without the macro, 02 follows the n_TWOCYCLE timing.
